// File: rtl/riscv_pkg.sv
// Shared types and constants for the core's data memory interface.
package riscv_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b11
    } mem_size_t;

    localparam logic [15:0] MMIO_TOHOST_OFS   = 16'h0;
    localparam logic [15:0] MMIO_CYCLE_LO_OFS = 16'h4;
    localparam logic [15:0] MMIO_CYCLE_HI_OFS = 16'h8;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: store strobes/replication and load
// extraction/extension, plus alignment checking.
module dmem_lane_align
    import riscv_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        zero_extnd_i,
    input  logic [31:0] wr_data_i,
    input  logic [31:0] rd_raw_i,
    output logic [3:0]  wr_strb_o,
    output logic [31:0] wr_word_o,
    output logic [31:0] rd_data_o,
    output logic        misalign_o
);

    logic        is_byte, is_half;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        is_byte  = (size_i == MEM_BYTE);
        is_half  = (size_i == MEM_HALF);
        // 2'b10 falls through to word handling
        misalign_o = is_half ? addr_lo_i[0] : (!is_byte && addr_lo_i != 2'b00);
        byte_sel = rd_raw_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = addr_lo_i[1] ? rd_raw_i[31:16] : rd_raw_i[15:0];

        if (is_byte) begin
            wr_strb_o = 4'b0001 << addr_lo_i;
            wr_word_o = {4{wr_data_i[7:0]}};
            rd_data_o = {{24{!zero_extnd_i & byte_sel[7]}}, byte_sel};
        end else if (is_half) begin
            wr_strb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wr_word_o = {2{wr_data_i[15:0]}};
            rd_data_o = {{16{!zero_extnd_i & half_sel[15]}}, half_sel};
        end else begin
            wr_strb_o = 4'b1111;
            wr_word_o = wr_data_i;
            rd_data_o = rd_raw_i;
        end

        if (misalign_o) begin
            wr_strb_o = 4'b0000;
            rd_data_o = 32'h0;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: word RAM, MMIO window (tohost mailbox, cycle counter)
// and sticky misalignment reporting.
module data_mem_responder
    import riscv_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
    parameter              INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        data_mem_req_i,
    input  logic [31:0] data_mem_addr_i,
    input  logic [1:0]  data_mem_byte_en_i,
    input  logic        data_mem_zero_extnd_i,
    input  logic        data_mem_wr_i,
    input  logic [31:0] data_mem_wr_data_i,
    output logic [31:0] data_mem_rd_data_o,
    output logic        misalign_err_o,
    output logic [31:0] err_addr_o,
    output logic        tohost_valid_o,
    output logic [31:0] tohost_data_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0]      mem_q [DEPTH_WORDS];
    logic [63:0]      cycle_q, cycle_d;
    logic             misalign_err_q;
    logic [31:0]      err_addr_q, tohost_data_q;
    logic             tohost_valid_q;

    logic [IDX_W-1:0] idx;
    logic             is_mmio, size_word, misalign, ram_we, tohost_we;
    logic [31:0]      mmio_ofs, mmio_rd, lane_rd, wr_word;
    logic [3:0]       wr_strb;

    assign idx       = data_mem_addr_i[IDX_W+1:2];
    assign is_mmio   = (data_mem_addr_i >= MMIO_BASE);
    assign mmio_ofs  = data_mem_addr_i - MMIO_BASE;
    assign size_word = data_mem_byte_en_i[1];
    assign cycle_d   = cycle_q + 64'd1;

    dmem_lane_align u_align (
        .addr_lo_i    (data_mem_addr_i[1:0]),
        .size_i       (data_mem_byte_en_i),
        .zero_extnd_i (data_mem_zero_extnd_i),
        .wr_data_i    (data_mem_wr_data_i),
        .rd_raw_i     (mem_q[idx]),
        .wr_strb_o    (wr_strb),
        .wr_word_o    (wr_word),
        .rd_data_o    (lane_rd),
        .misalign_o   (misalign)
    );

    always_comb begin
        mmio_rd = 32'h0;
        if (size_word) begin
            if (mmio_ofs == {16'h0, MMIO_TOHOST_OFS})        mmio_rd = tohost_data_q;
            else if (mmio_ofs == {16'h0, MMIO_CYCLE_LO_OFS}) mmio_rd = cycle_q[31:0];
            else if (mmio_ofs == {16'h0, MMIO_CYCLE_HI_OFS}) mmio_rd = cycle_q[63:32];
        end
        data_mem_rd_data_o = 32'h0;
        if (data_mem_req_i && !data_mem_wr_i && !misalign)
            data_mem_rd_data_o = is_mmio ? mmio_rd : lane_rd;
    end

    assign ram_we    = data_mem_req_i && data_mem_wr_i && !misalign && !is_mmio;
    assign tohost_we = data_mem_req_i && data_mem_wr_i && !misalign && is_mmio && size_word
                       && (mmio_ofs == {16'h0, MMIO_TOHOST_OFS});

    // RAM is not reset, but a store is dropped while reset is held
    always_ff @(posedge clk) begin
        if (reset_n && ram_we) begin
            for (int b = 0; b < 4; b++)
                if (wr_strb[b]) mem_q[idx][8*b +: 8] <= wr_word[8*b +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_q        <= 64'h0;
            misalign_err_q <= 1'b0;
            err_addr_q     <= 32'h0;
            tohost_valid_q <= 1'b0;
            tohost_data_q  <= 32'h0;
        end else begin
            cycle_q <= cycle_d;
            if (tohost_we) begin
                tohost_valid_q <= 1'b1;
                tohost_data_q  <= data_mem_wr_data_i;
            end
            if (data_mem_req_i && misalign && !misalign_err_q) begin
                misalign_err_q <= 1'b1;
                err_addr_q     <= data_mem_addr_i;
            end
        end
    end

    assign misalign_err_o = misalign_err_q;
    assign err_addr_o     = err_addr_q;
    assign tohost_valid_o = tohost_valid_q;
    assign tohost_data_o  = tohost_data_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed and scoreboard-driven checks for data_mem_responder (16-word RAM).
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req, zx, wr;
    logic [31:0] addr, wd;
    logic [1:0]  be;
    logic [31:0] rd, err_addr, th_data;
    logic        mis, th_valid;

    int total = 0;
    int bad   = 0;

    logic [7:0] sb [64];

    data_mem_responder #(.DEPTH_WORDS(16)) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .data_mem_req_i        (req),
        .data_mem_addr_i       (addr),
        .data_mem_byte_en_i    (be),
        .data_mem_zero_extnd_i (zx),
        .data_mem_wr_i         (wr),
        .data_mem_wr_data_i    (wd),
        .data_mem_rd_data_o    (rd),
        .misalign_err_o        (mis),
        .err_addr_o            (err_addr),
        .tohost_valid_o        (th_valid),
        .tohost_data_o         (th_data)
    );

    always #5 clk = ~clk;

    task automatic st(input logic [31:0] a, input logic [1:0] b, input logic [31:0] d);
        @(negedge clk);
        req = 1; wr = 1; addr = a; be = b; wd = d; zx = 0;
        @(posedge clk); #1;
        req = 0; wr = 0;
    endtask

    task automatic ld(input logic [31:0] a, input logic [1:0] b, input logic z,
                      output logic [31:0] d);
        @(negedge clk);
        req = 1; wr = 0; addr = a; be = b; zx = z;
        #1 d = rd;
        @(posedge clk); #1;
        req = 0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        req = 0; wr = 0; addr = 0; be = 2'b11; zx = 0; wd = 0;
        reset_n = 0;
        repeat (2) @(negedge clk);
        total += 5;
        if (mis !== 1'b0)       begin bad++; $display("FAIL reset_mis got=%0b exp=0", mis); end
        if (err_addr !== 32'h0) begin bad++; $display("FAIL reset_err_addr got=%h exp=0", err_addr); end
        if (th_valid !== 1'b0)  begin bad++; $display("FAIL reset_th_valid got=%0b exp=0", th_valid); end
        if (th_data !== 32'h0)  begin bad++; $display("FAIL reset_th_data got=%h exp=0", th_data); end
        if (rd !== 32'h0)       begin bad++; $display("FAIL reset_rd_idle got=%h exp=0", rd); end
        reset_n = 1;
        repeat (5) @(posedge clk);
        ld(32'hFFFF_0004, 2'b11, 0, d);
        total++;
        if (d !== 32'd5) begin bad++; $display("FAIL cycle_lo_after_reset got=%0d exp=5", d); end
    endtask

    task automatic test_load_ext();
        logic [31:0] d;
        st(32'h10, 2'b11, 32'hDEADBEEF);
        ld(32'h13, 2'b00, 0, d); total++;
        if (d !== 32'hFFFFFFDE) begin bad++; $display("FAIL lb got=%h exp=ffffffde", d); end
        ld(32'h13, 2'b00, 1, d); total++;
        if (d !== 32'h000000DE) begin bad++; $display("FAIL lbu got=%h exp=000000de", d); end
        ld(32'h12, 2'b01, 0, d); total++;
        if (d !== 32'hFFFFDEAD) begin bad++; $display("FAIL lh got=%h exp=ffffdead", d); end
        ld(32'h12, 2'b01, 1, d); total++;
        if (d !== 32'h0000DEAD) begin bad++; $display("FAIL lhu got=%h exp=0000dead", d); end
        ld(32'h11, 2'b00, 0, d); total++;
        if (d !== 32'hFFFFFFBE) begin bad++; $display("FAIL lb1 got=%h exp=ffffffbe", d); end
        ld(32'h10, 2'b01, 0, d); total++;
        if (d !== 32'hFFFFBEEF) begin bad++; $display("FAIL lh0 got=%h exp=ffffbeef", d); end
        ld(32'h10, 2'b11, 1, d); total++;
        if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_zx got=%h exp=deadbeef", d); end
        // store cycle drives rd to zero
        @(negedge clk); req = 1; wr = 1; addr = 32'h10; be = 2'b11; wd = 32'hDEADBEEF;
        #1 total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL rd_during_store got=%h exp=0", rd); end
        @(posedge clk); #1 req = 0; wr = 0;
    endtask

    task automatic test_partial_store();
        logic [31:0] d;
        st(32'h20, 2'b11, 32'h11223344);
        st(32'h21, 2'b00, 32'hFFFFFF55);
        ld(32'h20, 2'b11, 0, d); total++;
        if (d !== 32'h11225544) begin bad++; $display("FAIL sb_merge got=%h exp=11225544", d); end
        st(32'h22, 2'b01, 32'h1234AAAA);
        ld(32'h20, 2'b11, 0, d); total++;
        if (d !== 32'hAAAA5544) begin bad++; $display("FAIL sh_merge got=%h exp=aaaa5544", d); end
        st(32'h24, 2'b10, 32'hCAFEF00D);
        ld(32'h24, 2'b11, 0, d); total++;
        if (d !== 32'hCAFEF00D) begin bad++; $display("FAIL be10_word got=%h exp=cafef00d", d); end
    endtask

    task automatic test_misalign();
        logic [31:0] d;
        st(32'h08, 2'b11, 32'h01020304);
        ld(32'h06, 2'b11, 0, d);
        total += 3;
        if (d !== 32'h0)        begin bad++; $display("FAIL mis_rd got=%h exp=0", d); end
        if (mis !== 1'b1)       begin bad++; $display("FAIL mis_flag got=%0b exp=1", mis); end
        if (err_addr !== 32'h6) begin bad++; $display("FAIL mis_addr got=%h exp=6", err_addr); end
        st(32'h09, 2'b01, 32'h0000FFFF);
        st(32'h0A, 2'b11, 32'hFFFFFFFF);
        ld(32'h08, 2'b11, 0, d);
        total += 3;
        if (err_addr !== 32'h6) begin bad++; $display("FAIL mis_addr_sticky got=%h exp=6", err_addr); end
        if (mis !== 1'b1)       begin bad++; $display("FAIL mis_flag_sticky got=%0b exp=1", mis); end
        if (d !== 32'h01020304) begin bad++; $display("FAIL mis_no_write got=%h exp=01020304", d); end
    endtask

    task automatic test_cycle_hi();
        @(negedge clk);
        force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
        req = 1; wr = 0; be = 2'b11; addr = 32'hFFFF_0008;
        #1 total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL cycle_hi_before got=%h exp=0", rd); end
        addr = 32'hFFFF_0004;
        #1 total++;
        if (rd !== 32'hFFFFFFFF) begin bad++; $display("FAIL cycle_lo_forced got=%h exp=ffffffff", rd); end
        release dut.cycle_q;
        @(posedge clk); #1;
        addr = 32'hFFFF_0008;
        #1 total++;
        if (rd !== 32'h1) begin bad++; $display("FAIL cycle_hi_carry got=%h exp=1", rd); end
        addr = 32'hFFFF_0004;
        #1 total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL cycle_lo_wrap got=%h exp=0", rd); end
        req = 0;
    endtask

    task automatic test_tohost();
        logic [31:0] d;
        st(32'hFFFF_0000, 2'b01, 32'h0000_0042);
        st(32'hFFFF_0002, 2'b11, 32'h0000_0043);
        st(32'hFFFF_0010, 2'b11, 32'h0000_0044);
        total += 2;
        if (th_valid !== 1'b0) begin bad++; $display("FAIL th_dropped_valid got=%0b exp=0", th_valid); end
        if (th_data !== 32'h0) begin bad++; $display("FAIL th_dropped_data got=%h exp=0", th_data); end
        ld(32'hFFFF_0010, 2'b11, 0, d); total++;
        if (d !== 32'h0) begin bad++; $display("FAIL mmio_unmapped got=%h exp=0", d); end
        st(32'hFFFF_0000, 2'b11, 32'h1);
        total += 2;
        if (th_valid !== 1'b1) begin bad++; $display("FAIL th_valid got=%0b exp=1", th_valid); end
        if (th_data !== 32'h1) begin bad++; $display("FAIL th_data got=%h exp=1", th_data); end
        ld(32'hFFFF_0000, 2'b11, 0, d); total++;
        if (d !== 32'h1) begin bad++; $display("FAIL th_load got=%h exp=1", d); end
        ld(32'hFFFF_0000, 2'b00, 0, d); total++;
        if (d !== 32'h0) begin bad++; $display("FAIL th_byte_load got=%h exp=0", d); end
        // reset lands in the middle of a tohost store
        @(negedge clk); req = 1; wr = 1; addr = 32'hFFFF_0000; be = 2'b11; wd = 32'h77;
        #2 reset_n = 0;
        #1 total += 3;
        if (th_valid !== 1'b0) begin bad++; $display("FAIL rst_th_valid got=%0b exp=0", th_valid); end
        if (th_data !== 32'h0) begin bad++; $display("FAIL rst_th_data got=%h exp=0", th_data); end
        if (mis !== 1'b0)      begin bad++; $display("FAIL rst_mis got=%0b exp=0", mis); end
        @(posedge clk);
        @(negedge clk); req = 0; wr = 0; reset_n = 1;
        #1 total += 1;
        if (th_data !== 32'h0) begin bad++; $display("FAIL rst_th_discard got=%h exp=0", th_data); end
        // RAM store during reset is discarded, contents retained
        @(negedge clk); reset_n = 0; req = 1; wr = 1; addr = 32'h20; be = 2'b11; wd = 32'h99;
        @(posedge clk);
        @(negedge clk); req = 0; wr = 0; reset_n = 1;
        ld(32'h20, 2'b11, 0, d); total++;
        if (d !== 32'hAAAA5544) begin bad++; $display("FAIL ram_kept got=%h exp=aaaa5544", d); end
    endtask

    task automatic test_random();
        logic [31:0] d, exp, a;
        logic [1:0]  b;
        logic [7:0]  by;
        logic [15:0] hw;
        logic        z;
        int          s, i;
        for (int w = 0; w < 16; w++) st(32'(w * 4), 2'b11, 32'h0);
        for (int k = 0; k < 64; k++) sb[k] = 8'h0;
        for (int n = 0; n < 300; n++) begin
            s = $urandom_range(0, 2);
            b = (s == 0) ? 2'b00 : (s == 1) ? 2'b01 : 2'b11;
            a = 32'($urandom_range(0, 255));
            if (s == 1) a[0] = 1'b0;
            if (s == 2) a[1:0] = 2'b00;
            d = $urandom;
            z = 1'($urandom_range(0, 1));
            i = int'(a[5:0]);
            if ($urandom_range(0, 1) == 1) begin
                st(a, b, d);
                sb[i] = d[7:0];
                if (s >= 1) sb[i+1] = d[15:8];
                if (s == 2) begin sb[i+2] = d[23:16]; sb[i+3] = d[31:24]; end
            end else begin
                ld(a, b, z, d);
                by = sb[i];
                hw = {sb[i+1], sb[i]};
                if (s == 0)      exp = {{24{!z & by[7]}}, by};
                else if (s == 1) exp = {{16{!z & hw[15]}}, hw};
                else             exp = {sb[i+3], sb[i+2], sb[i+1], sb[i]};
                total++;
                if (d !== exp) begin
                    bad++;
                    $display("FAIL rand_load addr=%h size=%0d got=%h exp=%h", a, s, d, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_ext();
        test_partial_store();
        test_misalign();
        test_cycle_hi();
        test_tohost();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
